// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction/data memory handshake between the controller and the memories
interface multicycle_controller_if;
  logic       imem_req;
  logic       imem_ready;
  logic       ir_write;
  logic [6:0] opcode;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ready;
  modport master(output imem_req, ir_write, dmem_req, dmem_we, input imem_ready, dmem_ready, opcode);
  modport slave(input imem_req, ir_write, dmem_req, dmem_we, output imem_ready, dmem_ready, opcode);
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle RV64 control FSM sequencing fetch/decode/execute/memory/writeback
module multicycle_controller #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       zero,
  multicycle_controller_if.master    mem,
  output logic                       reg_write,
  output logic                       alu_src,
  output logic [1:0]                 alu_op,
  output logic                       mem_to_reg,
  output logic                       pc_write,
  output logic                       pc_src,
  output logic [2:0]                 state,
  output logic                       halted,
  output logic                       illegal,
  output logic                       timeout,
  output logic [CNT_W-1:0]           instr_count
);
  localparam int WW = $clog2(WAIT_LIMIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LIMIT - 1);
  localparam logic [6:0] OP_LD = 7'b0000011, OP_SD = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BEQ = 7'b1100011;
  typedef enum logic [2:0] {IDLE = 3'd0, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT} state_t;
  state_t           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stop_pending_q, stop_pending_d, illegal_q, illegal_d, timeout_q, timeout_d;
  logic             is_ld, is_sd, is_r, is_i, is_beq, active, retire;
  assign is_ld  = op_q == OP_LD;
  assign is_sd  = op_q == OP_SD;
  assign is_r   = op_q == OP_R;
  assign is_i   = op_q == OP_I;
  assign is_beq = op_q == OP_BEQ;
  assign active = state_q inside {DECODE, EXECUTE, MEMORY, WRITEBACK};
  assign alu_src     = active & (is_ld | is_sd | is_i);
  assign alu_op      = !active ? 2'b00 : is_beq ? 2'b01 : is_r ? 2'b10 : is_i ? 2'b11 : 2'b00;
  assign mem_to_reg  = active & is_ld;
  assign state       = state_q;
  assign halted      = state_q == HALT;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign instr_count = cnt_q;
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wait_d       = '0;
    cnt_d        = cnt_q;
    illegal_d    = illegal_q;
    timeout_d    = timeout_q;
    retire       = 1'b0;
    mem.imem_req = 1'b0;
    mem.ir_write = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    reg_write    = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    case (state_q)
      IDLE: state_d = start ? FETCH : IDLE;
      FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ready) begin
          mem.ir_write = 1'b1;
          op_d         = mem.opcode;
          state_d      = DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = HALT;
          timeout_d = 1'b1;
        end else wait_d = wait_q + WW'(1);
      end
      DECODE: begin
        state_d   = (is_ld | is_sd | is_r | is_i | is_beq) ? EXECUTE : HALT;
        illegal_d = illegal_q | !(is_ld | is_sd | is_r | is_i | is_beq);
      end
      EXECUTE: begin
        pc_write = is_beq;
        pc_src   = is_beq & zero;
        retire   = is_beq;
        state_d  = (is_ld | is_sd) ? MEMORY : WRITEBACK;
      end
      MEMORY: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = is_sd;
        if (mem.dmem_ready) begin
          state_d  = WRITEBACK;
          pc_write = is_sd;
          retire   = is_sd;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = HALT;
          timeout_d = 1'b1;
        end else wait_d = wait_q + WW'(1);
      end
      WRITEBACK: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
      end
      default: state_d = HALT;
    endcase
    // retirement overrides the per-state successor
    if (retire) begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = (stop | stop_pending_q) ? HALT : FETCH;
    end
    stop_pending_d = (state_d == HALT) ? 1'b0
                   : stop_pending_q | (stop & state_q != IDLE & state_q != HALT);
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state_q        <= IDLE;
      op_q           <= '0;
      wait_q         <= '0;
      cnt_q          <= '0;
      stop_pending_q <= 1'b0;
      illegal_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      wait_q         <= wait_d;
      cnt_q          <= cnt_d;
      stop_pending_q <= stop_pending_d;
      illegal_q      <= illegal_d;
      timeout_q      <= timeout_d;
    end
endmodule
